// File: rtl/hls_run_sequencer.sv
// Command-driven sequencer for a Bambu kernel: kernel reset, memory preload/readback
// over slave channel 0, and timed start/done runs, with a single response per command.
module hls_run_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int SIZE_W      = 7,
    parameter int CYC_W       = 32,
    parameter int RUN_TIMEOUT = 200000000,
    parameter int MEM_TIMEOUT = 16,
    parameter int KRST_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [SIZE_W-1:0]     cmd_size,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [CYC_W-1:0]      rsp_cycles,
    output logic                  main_reset_n,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    localparam int MEM_CW  = $clog2(MEM_TIMEOUT + 1);
    localparam int KRST_CW = $clog2(KRST_CYCLES + 1);

    localparam logic [CYC_W-1:0]   RUN_LIMIT = CYC_W'(RUN_TIMEOUT);
    localparam logic [MEM_CW-1:0]  MEM_LAST  = MEM_CW'(MEM_TIMEOUT - 1);
    localparam logic [KRST_CW-1:0] KRST_LAST = KRST_CW'(KRST_CYCLES - 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_RUN_TO  = 2'b10;
    localparam logic [1:0] ST_MEM_TO  = 2'b11;

    typedef enum logic [2:0] {
        KRST, IDLE, WR, RD, START, RUN, RESP
    } state_t;

    state_t              state;
    logic [KRST_CW-1:0]  krst_cnt;
    logic                krst_from_cmd;
    logic [MEM_CW-1:0]   mem_cnt;
    logic [CYC_W-1:0]    cyc_cnt;

    logic                oe0;
    logic                we0;
    logic [ADDR_W-1:0]   s_addr0;
    logic [DATA_W-1:0]   s_wdata0;
    logic [SIZE_W-1:0]   s_size0;

    // Only channel 0 of the slave port is used; channel 1 inputs are sunk here.
    logic unused_ch1;
    assign unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

    assign S_oe_ram        = {1'b0, oe0};
    assign S_we_ram        = {1'b0, we0};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, s_addr0};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, s_wdata0};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, s_size0};

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == {CYC_W{1'b1}}) ? v : v + CYC_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= KRST;
            krst_cnt      <= '0;
            krst_from_cmd <= 1'b0;
            mem_cnt       <= '0;
            cyc_cnt       <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_status    <= '0;
            rsp_data      <= '0;
            rsp_cycles    <= '0;
            main_reset_n  <= 1'b0;
            start_port    <= 1'b0;
            oe0           <= 1'b0;
            we0           <= 1'b0;
            s_addr0       <= '0;
            s_wdata0      <= '0;
            s_size0       <= '0;
        end else begin
            case (state)
                KRST: begin
                    if (krst_cnt == KRST_LAST) begin
                        krst_cnt     <= '0;
                        main_reset_n <= 1'b1;
                        if (krst_from_cmd) begin
                            krst_from_cmd <= 1'b0;
                            rsp_status    <= ST_OK;
                            rsp_valid     <= 1'b1;
                            state         <= RESP;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        krst_cnt <= krst_cnt + KRST_CW'(1);
                    end
                end

                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready  <= 1'b0;
                        mem_cnt    <= '0;
                        rsp_status <= '0;
                        rsp_data   <= '0;
                        rsp_cycles <= '0;
                        case (cmd_op)
                            OP_WRITE: begin
                                we0      <= 1'b1;
                                s_addr0  <= cmd_addr;
                                s_wdata0 <= cmd_wdata;
                                s_size0  <= cmd_size;
                                state    <= WR;
                            end
                            OP_READ: begin
                                oe0     <= 1'b1;
                                s_addr0 <= cmd_addr;
                                s_size0 <= cmd_size;
                                state   <= RD;
                            end
                            OP_RUN: begin
                                start_port <= 1'b1;
                                cyc_cnt    <= CYC_W'(1);
                                state      <= START;
                            end
                            default: begin
                                main_reset_n  <= 1'b0;
                                krst_cnt      <= '0;
                                krst_from_cmd <= 1'b1;
                                state         <= KRST;
                            end
                        endcase
                    end
                end

                // Enables stay up until DataRdy or the wait budget runs out.
                WR, RD: begin
                    if (Sout_DataRdy[0] || mem_cnt == MEM_LAST) begin
                        if (Sout_DataRdy[0]) begin
                            rsp_status <= ST_OK;
                            if (state == RD) begin
                                rsp_data <= Sout_Rdata_ram[DATA_W-1:0];
                            end
                        end else begin
                            rsp_status <= ST_MEM_TO;
                        end
                        we0       <= 1'b0;
                        oe0       <= 1'b0;
                        s_addr0   <= '0;
                        s_wdata0  <= '0;
                        s_size0   <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        mem_cnt <= mem_cnt + MEM_CW'(1);
                    end
                end

                // cyc_cnt always holds the number of the current run cycle (START = 1).
                START, RUN: begin
                    start_port <= 1'b0;
                    if (done_port) begin
                        rsp_status <= ST_OK;
                        rsp_cycles <= cyc_cnt;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (cyc_cnt >= RUN_LIMIT) begin
                        rsp_status <= ST_RUN_TO;
                        rsp_cycles <= RUN_LIMIT;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cyc_cnt <= sat_inc(cyc_cnt);
                        state   <= RUN;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_status <= '0;
                        rsp_data   <= '0;
                        rsp_cycles <= '0;
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    main_reset_n <= 1'b0;
                    krst_cnt     <= '0;
                    state        <= KRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer: a slave-memory model on channel 0, a driven
// done_port, and a second instance with a short run timeout.
module tb_hls_run_sequencer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int SIZE_W = 7;
    localparam int CYC_W  = 32;

    typedef struct packed {
        logic [1:0]        st;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cyc;
    } rsp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0, cmd_valid_t = 1'b0;
    logic [1:0]          cmd_op = '0;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [DATA_W-1:0]   cmd_wdata = '0;
    logic [SIZE_W-1:0]   cmd_size = '0;
    logic                rsp_ready = 1'b0, rsp_ready_t = 1'b0;
    logic                done_port = 1'b0;
    logic [2*DATA_W-1:0] Sout_Rdata_ram;
    logic [1:0]          Sout_DataRdy;

    logic                cmd_ready, rsp_valid, main_reset_n, start_port;
    logic [1:0]          rsp_status, S_oe_ram, S_we_ram;
    logic [DATA_W-1:0]   rsp_data;
    logic [CYC_W-1:0]    rsp_cycles;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram;
    logic [2*SIZE_W-1:0] S_data_ram_size;

    logic                cmd_ready_t, rsp_valid_t, main_reset_n_t, start_port_t;
    logic [1:0]          rsp_status_t, S_oe_ram_t, S_we_ram_t;
    logic [DATA_W-1:0]   rsp_data_t;
    logic [CYC_W-1:0]    rsp_cycles_t;
    logic [2*ADDR_W-1:0] S_addr_ram_t;
    logic [2*DATA_W-1:0] S_Wdata_ram_t;
    logic [2*SIZE_W-1:0] S_data_ram_size_t;

    hls_run_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .rsp_cycles(rsp_cycles),
        .main_reset_n(main_reset_n), .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    hls_run_sequencer #(.RUN_TIMEOUT(50)) dut_t (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_status(rsp_status_t),
        .rsp_data(rsp_data_t), .rsp_cycles(rsp_cycles_t),
        .main_reset_n(main_reset_n_t), .start_port(start_port_t), .done_port(done_port),
        .S_oe_ram(S_oe_ram_t), .S_we_ram(S_we_ram_t), .S_addr_ram(S_addr_ram_t),
        .S_Wdata_ram(S_Wdata_ram_t), .S_data_ram_size(S_data_ram_size_t),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    // Slave memory: DataRdy rises once the enable has been held mem_delay cycles.
    logic [7:0]        mem_wait = 8'd0;
    logic [7:0]        mem_delay = 8'd2;
    logic [DATA_W-1:0] mem_arr [0:1023];

    always_comb begin
        Sout_DataRdy    = 2'b00;
        Sout_DataRdy[0] = (S_we_ram[0] | S_oe_ram[0]) && (mem_wait == mem_delay);
        Sout_Rdata_ram  = {{DATA_W{1'b0}}, mem_arr[S_addr_ram[ADDR_W-1:0]]};
    end

    always @(posedge clock) begin
        if (reset || !(S_we_ram[0] | S_oe_ram[0])) mem_wait <= 8'd0;
        else mem_wait <= mem_wait + 8'd1;
        if (S_we_ram[0] && Sout_DataRdy[0]) mem_arr[S_addr_ram[ADDR_W-1:0]] <= S_Wdata_ram[DATA_W-1:0];
    end

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    rsp_t exp_r;
    rsp_t got_r;

    task automatic issue_cmd(input bit to_t, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [SIZE_W-1:0] size);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if ((to_t ? cmd_ready_t : cmd_ready) === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cmd_ready_wait: actual=0 required=1 within 50 cycles");
        end
        cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        if (to_t) cmd_valid_t = 1'b1; else cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0; cmd_valid_t = 1'b0;
    endtask

    task automatic ack_rsp(input bit to_t);
        if (to_t) rsp_ready_t = 1'b1; else rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0; rsp_ready_t = 1'b0;
    endtask

    // Watches the main instance after a command until rsp_valid; done_port rises in cycle done_at.
    task automatic watch_dut(input int budget, input int done_at, output int n_cyc,
                             output int we_c, output int oe_c, output int st_c,
                             output logic [2*ADDR_W+2*DATA_W+2*SIZE_W-1:0] snap, output bit got);
        bit taken = 0;
        n_cyc = 0; we_c = 0; oe_c = 0; st_c = 0; snap = '0; got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin got = 1; break; end
            n_cyc++;
            if (S_we_ram === 2'b01) we_c++;
            if (S_oe_ram === 2'b01) oe_c++;
            if (start_port === 1'b1) st_c++;
            if (!taken && (S_we_ram[0] | S_oe_ram[0])) begin
                taken = 1;
                snap  = {S_addr_ram, S_Wdata_ram, S_data_ram_size};
            end
            if (done_at != 0 && n_cyc == done_at) done_port = 1'b1;
        end
    endtask

    // From the negedge after the reset edge, counts kernel-reset cycles until cmd_ready.
    task automatic replay_count(output int low, output bit saw_rsp, output bit s_dirty, output bit ready);
        low = 0; saw_rsp = 0; s_dirty = 0; ready = 0;
        for (int i = 0; i < 12; i++) begin
            if (main_reset_n === 1'b0) low++;
            if (rsp_valid !== 1'b0) saw_rsp = 1;
            if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size} !== '0) s_dirty = 1;
            if (cmd_ready === 1'b1) begin ready = 1; break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        int low; bit saw, dirty, ready;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_cycles, main_reset_n, start_port} !== '0) begin
            failures++;
            $display("FAIL reset_state: actual ready=%b valid=%b mrst_n=%b start=%b required all zero",
                     cmd_ready, rsp_valid, main_reset_n, start_port);
        end
        reset = 1'b0;
        replay_count(low, saw, dirty, ready);
        checks++;
        if (low != 2 || !ready) begin
            failures++;
            $display("FAIL reset_krst_len: actual low=%0d ready=%b required low=2 ready=1", low, ready);
        end
        checks++;
        if (dirty || saw) begin
            failures++;
            $display("FAIL reset_outputs_quiet: actual s_dirty=%b rsp_seen=%b required 0 0", dirty, saw);
        end
    endtask

    task automatic test_write;
        int n, we_c, oe_c, st_c; bit got, stable;
        logic [2*ADDR_W+2*DATA_W+2*SIZE_W-1:0] snap;
        rsp_t held;
        mem_delay = 8'd2;
        exp_q.push_back('{st: 2'b00, data: '0, cyc: '0});
        issue_cmd(0, 2'd0, 10'h010, 64'h0000_0000_DEAD_BEEF, 7'd32);
        watch_dut(60, 0, n, we_c, oe_c, st_c, snap, got);
        checks++;
        if (!got || we_c != 3 || oe_c != 0) begin
            failures++;
            $display("FAIL write_we_cycles: actual got=%b we=%0d oe=%0d required got=1 we=3 oe=0", got, we_c, oe_c);
        end
        checks++;
        if (snap !== {10'h0, 10'h010, 64'h0, 64'h0000_0000_DEAD_BEEF, 7'd0, 7'd32}) begin
            failures++;
            $display("FAIL write_bus_fields: actual=%h required addr=010 data=deadbeef size=32", snap);
        end
        held = {rsp_status, rsp_data, rsp_cycles};
        stable = 1;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_status, rsp_data, rsp_cycles} !== held) stable = 0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL write_backpressure: actual stable=0 required stable=1");
        end
        exp_r = exp_q.pop_front();
        got_r = {rsp_status, rsp_data, rsp_cycles};
        checks++;
        if (got_r !== exp_r) begin
            failures++;
            $display("FAIL write_rsp: actual=%h required=%h", got_r, exp_r);
        end
        ack_rsp(0);
        @(negedge clock);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_handshake: actual valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read;
        int n, we_c, oe_c, st_c; bit got;
        logic [2*ADDR_W+2*DATA_W+2*SIZE_W-1:0] snap;
        mem_delay = 8'd2;
        exp_q.push_back('{st: 2'b00, data: 64'h0000_0000_DEAD_BEEF, cyc: '0});
        issue_cmd(0, 2'd1, 10'h010, '0, 7'd32);
        watch_dut(60, 0, n, we_c, oe_c, st_c, snap, got);
        exp_r = exp_q.pop_front();
        got_r = {rsp_status, rsp_data, rsp_cycles};
        checks++;
        if (!got || got_r !== exp_r) begin
            failures++;
            $display("FAIL read_rsp: actual=%h got=%b required=%h", got_r, got, exp_r);
        end
        checks++;
        if (oe_c != 3 || we_c != 0) begin
            failures++;
            $display("FAIL read_oe_cycles: actual oe=%0d we=%0d required oe=3 we=0", oe_c, we_c);
        end
        ack_rsp(0);

        mem_delay = 8'hFF;
        exp_q.push_back('{st: 2'b11, data: '0, cyc: '0});
        issue_cmd(0, 2'd1, 10'h020, '0, 7'd64);
        watch_dut(60, 0, n, we_c, oe_c, st_c, snap, got);
        exp_r = exp_q.pop_front();
        got_r = {rsp_status, rsp_data, rsp_cycles};
        checks++;
        if (!got || got_r !== exp_r) begin
            failures++;
            $display("FAIL read_timeout_rsp: actual=%h got=%b required=%h", got_r, got, exp_r);
        end
        checks++;
        if (oe_c != 16 || n != 16) begin
            failures++;
            $display("FAIL read_timeout_len: actual oe=%0d cycles=%0d required 16 16", oe_c, n);
        end
        checks++;
        if (S_oe_ram !== 2'b00) begin
            failures++;
            $display("FAIL read_timeout_oe_drop: actual=%b required=00", S_oe_ram);
        end
        ack_rsp(0);
        mem_delay = 8'd2;
    endtask

    task automatic test_run;
        int n, we_c, oe_c, st_c; bit got;
        logic [2*ADDR_W+2*DATA_W+2*SIZE_W-1:0] snap;
        done_port = 1'b0;
        exp_q.push_back('{st: 2'b00, data: '0, cyc: 32'd101});
        issue_cmd(0, 2'd2, '0, '0, '0);
        watch_dut(300, 101, n, we_c, oe_c, st_c, snap, got);
        done_port = 1'b0;
        exp_r = exp_q.pop_front();
        got_r = {rsp_status, rsp_data, rsp_cycles};
        checks++;
        if (!got || got_r !== exp_r) begin
            failures++;
            $display("FAIL run_101_rsp: actual=%h got=%b required=%h", got_r, got, exp_r);
        end
        checks++;
        if (st_c != 1) begin
            failures++;
            $display("FAIL run_start_pulse: actual=%0d required=1", st_c);
        end
        ack_rsp(0);

        done_port = 1'b1;
        exp_q.push_back('{st: 2'b00, data: '0, cyc: 32'd1});
        issue_cmd(0, 2'd2, '0, '0, '0);
        watch_dut(20, 0, n, we_c, oe_c, st_c, snap, got);
        done_port = 1'b0;
        exp_r = exp_q.pop_front();
        got_r = {rsp_status, rsp_data, rsp_cycles};
        checks++;
        if (!got || got_r !== exp_r || n != 1) begin
            failures++;
            $display("FAIL run_done_in_start: actual=%h cycles=%0d required=%h cycles=1", got_r, n, exp_r);
        end
        ack_rsp(0);
    endtask

    task automatic test_run_timeout;
        int n = 0, low = 0; bit got = 0;
        done_port = 1'b0;
        exp_q.push_back('{st: 2'b10, data: '0, cyc: 32'd50});
        issue_cmd(1, 2'd2, '0, '0, '0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (rsp_valid_t === 1'b1) begin got = 1; break; end
            n++;
        end
        exp_r = exp_q.pop_front();
        got_r = {rsp_status_t, rsp_data_t, rsp_cycles_t};
        checks++;
        if (!got || got_r !== exp_r) begin
            failures++;
            $display("FAIL run_timeout_rsp: actual=%h got=%b required=%h", got_r, got, exp_r);
        end
        checks++;
        if (n != 50) begin
            failures++;
            $display("FAIL run_timeout_len: actual=%0d required=50", n);
        end
        ack_rsp(1);

        exp_q.push_back('{st: 2'b00, data: '0, cyc: '0});
        issue_cmd(1, 2'd3, '0, '0, '0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid_t === 1'b1) begin got = 1; break; end
            if (main_reset_n_t === 1'b0) low++;
        end
        checks++;
        if (low != 2) begin
            failures++;
            $display("FAIL kreset_len: actual=%0d required=2", low);
        end
        exp_r = exp_q.pop_front();
        got_r = {rsp_status_t, rsp_data_t, rsp_cycles_t};
        checks++;
        if (!got || got_r !== exp_r || main_reset_n_t !== 1'b1) begin
            failures++;
            $display("FAIL kreset_rsp: actual=%h got=%b mrst_n=%b required=%h", got_r, got, main_reset_n_t, exp_r);
        end
        ack_rsp(1);
    endtask

    task automatic test_reset_mid_op(input bit in_write);
        int low; bit saw, dirty, ready, active = 0;
        done_port = 1'b0;
        mem_delay = 8'hFF;
        if (in_write) issue_cmd(0, 2'd0, 10'h030, 64'h1234, 7'd16);
        else issue_cmd(0, 2'd2, '0, '0, '0);
        repeat (in_write ? 3 : 20) @(negedge clock);
        active = in_write ? (S_we_ram === 2'b01) : (main_reset_n === 1'b1 && rsp_valid === 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (!active || {start_port, S_we_ram, S_oe_ram, rsp_valid, main_reset_n, cmd_ready} !== '0) begin
            failures++;
            $display("FAIL abort_%s: actual active=%b start=%b we=%b oe=%b valid=%b required active=1 rest 0",
                     in_write ? "wr" : "run", active, start_port, S_we_ram, S_oe_ram, rsp_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        replay_count(low, saw, dirty, ready);
        checks++;
        if (low != 2 || !ready || saw || dirty) begin
            failures++;
            $display("FAIL abort_replay_%s: actual low=%0d ready=%b rsp=%b s_dirty=%b required 2 1 0 0",
                     in_write ? "wr" : "run", low, ready, saw, dirty);
        end
        mem_delay = 8'd2;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_run();
        test_run_timeout();
        test_reset_mid_op(0);
        test_reset_mid_op(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Sequences one Bambu-generated kernel (start_port/done_port with the two-channel slave RAM port) from a command stream.
- Commands: kernel reset, preload words into kernel memory, start the kernel and time it, read results back.
- Replaces the behavioural testbench FSM with synthesizable control, so an on-board host can run the kernel on the Artix-7.
- Uses channel 0 of the slave port only; channel 1 is tied off.

Parameters:
- ADDR_W, 10, per-channel slave address width; S_addr_ram = 2*ADDR_W.
- DATA_W, 64, per-channel data width; S_Wdata_ram/Sout_Rdata_ram = 2*DATA_W.
- SIZE_W, 7, per-channel access-size field width; S_data_ram_size = 2*SIZE_W.
- CYC_W, 32, cycle counter width.
- RUN_TIMEOUT, 200000000, maximum kernel run cycles.
- MEM_TIMEOUT, 16, maximum cycles waiting for Sout_DataRdy.
- KRST_CYCLES, 2, cycles main_reset_n is held low.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high sequencer reset.
- cmd_valid  in  1  command handshake.
- cmd_ready  out  1  sequencer idle; accepts a command when cmd_valid is high.
- cmd_op  in  2  0=WRITE, 1=READ, 2=RUN, 3=KRESET.
- cmd_addr  in  ADDR_W  memory byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_size  in  SIZE_W  access size in bits (8/16/32/64).
- rsp_valid  out  1  response pending.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  00 OK, 10 run timeout, 11 memory timeout.
- rsp_data  out  DATA_W  read data (READ), else zero.
- rsp_cycles  out  CYC_W  kernel cycle count (RUN), else zero.
- main_reset_n  out  1  kernel reset, active-low.
- start_port  out  1  kernel start pulse.
- done_port  in  1  kernel done.
- S_oe_ram  out  2  slave read enables.
- S_we_ram  out  2  slave write enables.
- S_addr_ram  out  2*ADDR_W  slave addresses.
- S_Wdata_ram  out  2*DATA_W  slave write data.
- S_data_ram_size  out  2*SIZE_W  slave sizes.
- Sout_Rdata_ram  in  2*DATA_W  slave read data.
- Sout_DataRdy  in  2  slave data-ready.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- While `reset` is high:
  - cmd_ready=0, rsp_valid=0, rsp_* all zero.
  - main_reset_n=0, start_port=0, all S_* outputs zero.
  - Counters are cleared and the state is KRST.
- Channel 1 fields of all S_* outputs are constant zero.
- States:
  - KRST: main_reset_n=0 for KRST_CYCLES cycles, then IDLE. On entry via the KRESET command, go to RESP on exit, otherwise to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid, latch op/addr/wdata/size and go to WR, RD, START or KRST by op. cmd_ready drops the cycle after acceptance.
  - WR: S_we_ram[0]=1 with address/data/size driven every cycle until Sout_DataRdy[0] is sampled high. Then status 00 -> RESP.
  - RD: S_oe_ram[0]=1 until Sout_DataRdy[0]. Capture Sout_Rdata_ram[DATA_W-1:0] in that cycle, status 00 -> RESP.
  - WR/RD timeout: if MEM_TIMEOUT cycles elapse without DataRdy, drop the enables, status 11 -> RESP.
  - START: start_port=1 for exactly one cycle; cycle counter = 1; then RUN.
  - RUN: counter increments by 1 each cycle. When done_port is sampled high, rsp_cycles = counter value in that cycle, status 00 -> RESP.
  - RUN timeout: when the counter reaches RUN_TIMEOUT without done, status 10, rsp_cycles = RUN_TIMEOUT -> RESP. The kernel is not reset automatically; the host issues KRESET.
  - RESP: rsp_valid=1 with all rsp_* stable until rsp_ready is sampled high, then IDLE. rsp_valid and cmd_ready are never both high.
- Cycle-count convention: the start cycle counts as cycle 1. If done_port is already high during START, rsp_cycles=1 and the state goes directly to RESP.
- done_port is ignored outside START/RUN. A DataRdy arriving after a timeout is ignored.
- The counter saturates; it never wraps.
- A reset mid-operation (any state) aborts the operation, drops every enable in the next cycle, and re-enters KRST. Any pending response is discarded.

Test Plan:
- Reset release: after 1 cycle of reset -> main_reset_n low for exactly 2 cycles, then cmd_ready=1; all S_* zero throughout.
- WRITE addr=0x010, wdata=0x0000_0000_DEAD_BEEF, size=32, DataRdy after 2 cycles -> S_we_ram=2'b01 for 3 cycles, rsp_status=00. Back-pressure rsp_ready low for 4 cycles -> rsp held stable.
- READ addr=0x010, memory model returns 0xDEADBEEF with 2-cycle delay -> rsp_data=0xDEADBEEF, status 00; then DataRdy never asserted -> status 11 after exactly 16 cycles, S_oe_ram deasserted.
- RUN with kernel model raising done 100 cycles after start (start cycle = 1, done in cycle 101) -> start_port high exactly 1 cycle, rsp_cycles=101. Also done already high in the START cycle -> rsp_cycles=1.
- RUN with RUN_TIMEOUT overridden to 50 and done never raised -> status 10, rsp_cycles=50; a following KRESET -> main_reset_n low for 2 cycles, rsp status 00.
- Reset asserted in RUN cycle 20 and in WR with we high -> start/we/oe zero next cycle, no rsp_valid, KRST sequence replayed.
